// File: rtl/fir_sched_pkg.sv
// Shared types, default sizes and the output round/saturate helper for the FIR MAC scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fir_sched_pkg;

   localparam int NTAPS = 32;
   localparam int DW    = 16;
   localparam int ACC_W = 2*DW + $clog2(NTAPS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_ROUND = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   // Round half-up at the Q(dw-1) boundary, then clamp to the dw-bit signed range.
   // The accumulator is passed sign-extended to 64 bits so one helper serves any width.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int                 dw);
      logic signed [63:0] r;
      logic signed [63:0] maxv;
      logic signed [63:0] minv;
      r    = (acc + (64'sd1 <<< (dw-2))) >>> (dw-1);
      maxv = (64'sd1 <<< (dw-1)) - 64'sd1;
      minv = -(64'sd1 <<< (dw-1));
      if (r > maxv)
         round_sat = maxv;
      else if (r < minv)
         round_sat = minv;
      else
         round_sat = r;
   endfunction

endpackage

// File: rtl/fir_mac_sched_if.sv
// Sample, result and coefficient-programming signals of the FIR MAC scheduler.
// Latency: none (wiring only).
// Backpressure: sample_ready is advisory; samples offered while it is low are dropped.
interface fir_mac_sched_if #(
   parameter int NTAPS = fir_sched_pkg::NTAPS,
   parameter int DW    = fir_sched_pkg::DW
);
   logic signed [DW-1:0]            signal_in;
   logic                            sample_valid;
   logic                            sample_ready;
   logic signed [DW-1:0]            signal_out;
   logic                            result_valid;
   logic                            coef_wr_en;
   logic        [$clog2(NTAPS)-1:0] coef_wr_addr;
   logic signed [DW-1:0]            coef_wr_data;
   logic                            coef_swap;
   logic                            coef_swap_done;
   logic                            overrun;

   modport master (
      output signal_in, sample_valid, coef_wr_en, coef_wr_addr, coef_wr_data, coef_swap,
      input  sample_ready, signal_out, result_valid, coef_swap_done, overrun
   );

   modport slave (
      input  signal_in, sample_valid, coef_wr_en, coef_wr_addr, coef_wr_data, coef_swap,
      output sample_ready, signal_out, result_valid, coef_swap_done, overrun
   );
endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient register file: writes land in the shadow bank, reads come from the active bank.
// Latency: combinational read; writes and swaps take effect on the next edge.
// Backpressure: none; a write on the swap edge goes to the bank that becomes active.
module fir_coef_bank #(
   parameter int NTAPS = 32,
   parameter int DW    = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            wr_en_i,
   input  logic        [$clog2(NTAPS)-1:0] wr_addr_i,
   input  logic signed [DW-1:0]            wr_data_i,
   input  logic                            swap_i,
   input  logic        [$clog2(NTAPS)-1:0] rd_addr_i,
   output logic signed [DW-1:0]            rd_data_o
);

   logic                 sel_q;      // index of the active bank
   logic signed [DW-1:0] bank0_q [NTAPS];
   logic signed [DW-1:0] bank1_q [NTAPS];

   // Bank select flip and shadow-bank writes; the shadow is always the bank not selected.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            bank0_q[i] <= '0;
            bank1_q[i] <= '0;
         end
      end else begin
         if (swap_i)
            sel_q <= ~sel_q;
         if (wr_en_i) begin
            if (sel_q)
               bank0_q[wr_addr_i] <= wr_data_i;
            else
               bank1_q[wr_addr_i] <= wr_data_i;
         end
      end
   end

   assign rd_data_o = sel_q ? bank1_q[rd_addr_i] : bank0_q[rd_addr_i];

endmodule

// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR filter: one shared multiplier walks all taps per accepted sample.
// Latency: result_valid NTAPS+2 cycles after the accepting edge; one sample per NTAPS+3 cycles.
// Backpressure: sample_ready only in IDLE; samples offered elsewhere are dropped and flag overrun.
module fir_mac_sched #(
   parameter int NTAPS = fir_sched_pkg::NTAPS,
   parameter int DW    = fir_sched_pkg::DW
) (
   input logic            clk,
   input logic            reset,
   fir_mac_sched_if.slave bus
);
   import fir_sched_pkg::*;

   localparam int AW    = $clog2(NTAPS);
   localparam int MAC_W = 2*DW + AW;

   state_t                 state_q, state_d;
   logic        [AW-1:0]   k_q, k_d;
   logic        [AW-1:0]   wr_ptr_q;
   logic signed [MAC_W-1:0] acc_q, acc_d;
   logic signed [DW-1:0]   round_q, round_d;
   logic signed [DW-1:0]   signal_out_q, signal_out_d;
   logic                   result_valid_q, result_valid_d;
   logic                   pending_q;
   logic                   swap_done_q;
   logic                   overrun_q;
   logic signed [DW-1:0]   ring_q [NTAPS];

   logic                   accept;
   logic                   commit;
   logic        [AW-1:0]   rd_idx;
   logic signed [DW-1:0]   coef_rd;
   logic signed [2*DW-1:0] prod;
   logic signed [MAC_W-1:0] prod_ext;
   logic signed [63:0]     acc_ext;

   assign accept = (state_q == ST_IDLE) && bus.sample_valid;
   // A sample in the same IDLE cycle wins; the swap waits for the next IDLE.
   assign commit = (state_q == ST_IDLE) && pending_q && !bus.sample_valid;

   // wr_ptr already advanced past the newest sample, so tap k reads one behind it.
   assign rd_idx   = wr_ptr_q - k_q - AW'(1);
   assign prod     = ring_q[rd_idx] * coef_rd;
   assign prod_ext = {{(MAC_W-2*DW){prod[2*DW-1]}}, prod};
   assign acc_ext  = {{(64-MAC_W){acc_q[MAC_W-1]}}, acc_q};

   fir_coef_bank #(.NTAPS(NTAPS), .DW(DW)) u_coef_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (bus.coef_wr_en),
      .wr_addr_i (bus.coef_wr_addr),
      .wr_data_i (bus.coef_wr_data),
      .swap_i    (commit),
      .rd_addr_i (k_q),
      .rd_data_o (coef_rd)
   );

   // Sequencer next-state and datapath updates for IDLE -> MAC -> ROUND -> OUT.
   always_comb begin
      state_d        = state_q;
      k_d            = k_q;
      acc_d          = acc_q;
      round_d        = round_q;
      signal_out_d   = signal_out_q;
      result_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.sample_valid) begin
               acc_d   = '0;
               k_d     = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_d = acc_q + prod_ext;
            k_d   = k_q + AW'(1);
            if (k_q == AW'(NTAPS-1))
               state_d = ST_ROUND;
         end
         ST_ROUND: begin
            round_d = DW'(round_sat(acc_ext, DW));
            state_d = ST_OUT;
         end
         ST_OUT: begin
            signal_out_d   = round_q;
            result_valid_d = 1'b1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer and datapath registers; reset aborts any sample in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         k_q            <= '0;
         acc_q          <= '0;
         round_q        <= '0;
         signal_out_q   <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         k_q            <= k_d;
         acc_q          <= acc_d;
         round_q        <= round_d;
         signal_out_q   <= signal_out_d;
         result_valid_q <= result_valid_d;
      end
   end

   // Sample history ring; only accepted samples are written and advance the pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         for (int i = 0; i < NTAPS; i++)
            ring_q[i] <= '0;
      end else if (accept) begin
         ring_q[wr_ptr_q] <= bus.signal_in;
         wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
   end

   // Swap request tracking, commit pulse and the sticky drop flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q   <= 1'b0;
         swap_done_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         pending_q   <= commit ? 1'b0 : (pending_q | bus.coef_swap);
         swap_done_q <= commit;
         if (bus.sample_valid && (state_q != ST_IDLE))
            overrun_q <= 1'b1;
      end
   end

   assign bus.sample_ready   = (state_q == ST_IDLE) && !reset;
   assign bus.signal_out     = signal_out_q;
   assign bus.result_valid   = result_valid_q;
   assign bus.coef_swap_done = swap_done_q;
   assign bus.overrun        = overrun_q;

endmodule
